vec_class_stat: RTL and testbench
=================================

Name: vec_class_stat

Overview:
- Streaming classifier and statistics collector for WIDTH-bit vectors.
- Each accepted vector is classified as ZERO, ONEHOT, ALL_ONES, MULTI (2..WIDTH-1 ones) or UNKNOWN (any X/Z bit).
- Each vector is forwarded with its class code and bumps a per-class saturating counter.
- Sits directly downstream of the vector generator/checker stage and feeds scoreboard/report logic.

Parameters:
- WIDTH, 4, data vector width (>=1).
- CNT_W, 8, width of each statistics counter.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept an input vector.
- in_data  input  WIDTH  vector to classify (4-state; X/Z is meaningful).
- out_valid  output  1  classified vector available.
- out_ready  input  1  downstream accepts the output.
- out_data  output  WIDTH  registered copy of the accepted vector.
- out_class  output  3  class code: 0 ZERO, 1 ONEHOT, 2 ALL_ONES, 3 MULTI, 4 UNKNOWN.
- clr  input  1  synchronous clear of all counters (and error state, if enabled).
- cnt_zero, cnt_onehot, cnt_ones, cnt_multi, cnt_unknown  output  CNT_W each  per-class counters.
- cnt_total  output  CNT_W  count of all accepted vectors.

Behaviour:
- Reset (rstn low, asynchronous): out_valid=0, out_data=0, out_class=0, all counters=0. in_ready follows its combinational equation.
- Reset asserted mid-transfer discards the held output; the in-flight vector is lost and is not counted.
- Handshake:
  - Single output register, valid/ready protocol.
  - in_ready = !out_valid || out_ready (combinational; no bubble on back-to-back transfers).
  - Accept occurs when in_valid && in_ready at a clock edge.
- Latency: a vector accepted at edge N appears on out_data/out_class with out_valid=1 after edge N.
- out_valid and out_data are held stable while out_valid && !out_ready.
- out_valid drops after the edge where out_ready is seen with no new accept.
- Classification priority (first match wins):
  - UNKNOWN when $isunknown(in_data).
  - ZERO when in_data===0.
  - ONEHOT when $onehot(in_data).
  - ALL_ONES when in_data==='1.
  - Otherwise MULTI.
  - For WIDTH=1, a value of 1 classifies ONEHOT, never ALL_ONES.
- Comparisons use case equality (===) so X/Z never propagates into the class code.
- Counters:
  - On each accept, cnt_total and the matching class counter increment at the same edge, visible from cycle N+1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - Counters are independent of out_ready; counting happens at accept, not at output.
- clr:
  - Synchronous; all counters go to 0 at the edge.
  - If an accept coincides with clr, clr wins: counters read 0, not 1. The vector is still forwarded normally.
  - clr does not affect out_valid/out_data/out_class.
- out_data for an UNKNOWN vector carries the X/Z bits unchanged.

Optional Feature:
- Macro VEC_CLASS_STICKY_ERR_EN adds a two-state FSM: RUN and ERR.
- With the macro:
  - RUN -> ERR on the edge that accepts an UNKNOWN vector. That vector is still forwarded and counted.
  - In ERR, in_ready is forced 0. Pending output still drains via out_ready.
  - ERR -> RUN only on clr, which also zeroes the counters.
  - If clr and an UNKNOWN accept occur in the same cycle, the FSM stays in RUN (clr wins).
  - Reset returns the FSM to RUN.
- Without the macro: no FSM; UNKNOWN vectors are only counted and forwarded, and in_ready follows the handshake equation alone.

Test Plan:
- Reset then stream 'b1000, 'b1111, 'b0110, 'b0000 with out_ready=1 -> out_class 1,2,3,0 on consecutive cycles, one cycle latency; cnt_onehot=1, cnt_ones=1, cnt_multi=1, cnt_zero=1, cnt_total=4.
- Send 'b111x -> out_class=4, out_data shows 111x, cnt_unknown=1. With VEC_CLASS_STICKY_ERR_EN, in_ready=0 afterwards until clr pulse, then in_ready=1 and all counters 0.
- Hold out_ready=0 with in_valid=1 for 5 cycles after first accept -> in_ready=0, out_data stable, cnt_total=1. Release out_ready -> next vector accepted the same cycle with no bubble.
- CNT_W=2, send 5 ONEHOT vectors -> cnt_onehot and cnt_total saturate at 3 and do not wrap to 0.
- Assert clr in the same cycle as an accepted 'b0010 -> all counters 0 next cycle; out_class=1 still presented.
- Drop rstn asynchronously mid-cycle while out_valid=1 and out_ready=0 -> out_valid=0 and counters 0 immediately, without waiting for a clock edge. After release, the stream resumes normally.

Source files
------------

// File: rtl/vec_class_stat.sv
// vec_class_stat: classifies each accepted WIDTH-bit vector, forwards it through one output register
// and keeps saturating per-class counters. Define VEC_CLASS_STICKY_ERR_EN to stall input after an UNKNOWN.
module vec_class_stat #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       out_class,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_zero,
   output logic [CNT_W-1:0] cnt_onehot,
   output logic [CNT_W-1:0] cnt_ones,
   output logic [CNT_W-1:0] cnt_multi,
   output logic [CNT_W-1:0] cnt_unknown,
   output logic [CNT_W-1:0] cnt_total
);

   localparam int unsigned NUM_CLS = 5;
   localparam logic [2:0] CLS_ZERO    = 3'd0;
   localparam logic [2:0] CLS_ONEHOT  = 3'd1;
   localparam logic [2:0] CLS_ONES    = 3'd2;
   localparam logic [2:0] CLS_MULTI   = 3'd3;
   localparam logic [2:0] CLS_UNKNOWN = 3'd4;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [2:0]       out_class_q, out_class_d;
   logic [CNT_W-1:0] cnt_q [NUM_CLS];
   logic [CNT_W-1:0] cnt_d [NUM_CLS];
   logic [CNT_W-1:0] total_q, total_d;
   logic [2:0]       cls_c;
   logic             accept_c;
   logic             err_c;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Case equality keeps X/Z out of the class code; ONEHOT ahead of ALL_ONES covers WIDTH=1.
   always_comb begin
      cls_c = CLS_MULTI;
      if ($isunknown(in_data))     cls_c = CLS_UNKNOWN;
      else if (in_data === '0)     cls_c = CLS_ZERO;
      else if ($onehot(in_data))   cls_c = CLS_ONEHOT;
      else if (in_data === '1)     cls_c = CLS_ONES;
   end

`ifdef VEC_CLASS_STICKY_ERR_EN
   localparam logic [0:0] ST_RUN = 1'b0;
   localparam logic [0:0] ST_ERR = 1'b1;

   logic [0:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (clr)                                   state_d = ST_RUN;
      else if (accept_c && cls_c == CLS_UNKNOWN) state_d = ST_ERR;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= ST_RUN;
      else       state_q <= state_d;
   end

   assign err_c = (state_q == ST_ERR);
`else
   assign err_c = 1'b0;
`endif

   assign in_ready = (!out_valid_q || out_ready) && !err_c;
   assign accept_c = in_valid && in_ready;

   // Output register and counters; clr overrides a coincident accept for the counters only.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_class_d = out_class_q;
      total_d     = total_q;
      for (int i = 0; i < int'(NUM_CLS); i++) cnt_d[i] = cnt_q[i];

      if (accept_c) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data;
         out_class_d = cls_c;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (clr) begin
         total_d = '0;
         for (int i = 0; i < int'(NUM_CLS); i++) cnt_d[i] = '0;
      end else if (accept_c) begin
         total_d = sat_inc(total_q);
         for (int i = 0; i < int'(NUM_CLS); i++)
            if (cls_c == 3'(i)) cnt_d[i] = sat_inc(cnt_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_class_q <= CLS_ZERO;
         total_q     <= '0;
         for (int i = 0; i < int'(NUM_CLS); i++) cnt_q[i] <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_class_q <= out_class_d;
         total_q     <= total_d;
         for (int i = 0; i < int'(NUM_CLS); i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_class   = out_class_q;
   assign cnt_zero    = cnt_q[CLS_ZERO];
   assign cnt_onehot  = cnt_q[CLS_ONEHOT];
   assign cnt_ones    = cnt_q[CLS_ONES];
   assign cnt_multi   = cnt_q[CLS_MULTI];
   assign cnt_unknown = cnt_q[CLS_UNKNOWN];
   assign cnt_total   = total_q;

endmodule

// File: tb/tb_vec_class_stat.sv
// Directed self-checking bench for vec_class_stat: main instance (CNT_W=8) plus a CNT_W=2 instance
// used for counter saturation.
module tb_vec_class_stat;

   logic       clk;
   logic       rstn;
   logic       in_valid, in_ready, out_valid, out_ready, clr;
   logic [3:0] in_data, out_data;
   logic [2:0] out_class;
   logic [7:0] cnt_zero, cnt_onehot, cnt_ones, cnt_multi, cnt_unknown, cnt_total;

   logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [3:0] s_in_data, s_out_data;
   logic [2:0] s_out_class;
   logic [1:0] s_cnt_zero, s_cnt_onehot, s_cnt_ones, s_cnt_multi, s_cnt_unknown, s_cnt_total;

   int errors = 0;
   int checks = 0;

   vec_class_stat #(.WIDTH(4), .CNT_W(8)) u_dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_class(out_class),
      .clr(clr), .cnt_zero(cnt_zero), .cnt_onehot(cnt_onehot), .cnt_ones(cnt_ones),
      .cnt_multi(cnt_multi), .cnt_unknown(cnt_unknown), .cnt_total(cnt_total)
   );

   vec_class_stat #(.WIDTH(4), .CNT_W(2)) u_sat (
      .clk(clk), .rstn(rstn), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_class(s_out_class),
      .clr(clr), .cnt_zero(s_cnt_zero), .cnt_onehot(s_cnt_onehot), .cnt_ones(s_cnt_ones),
      .cnt_multi(s_cnt_multi), .cnt_unknown(s_cnt_unknown), .cnt_total(s_cnt_total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b1; clr = 1'b0;
      s_in_valid = 1'b0; s_in_data = 4'h0; s_out_ready = 1'b1;
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data got=%b exp=0000", out_data); end
      checks++; if (out_class !== 3'd0) begin errors++; $display("FAIL reset_out_class got=%0d exp=0", out_class); end
      checks++; if (cnt_total !== 8'd0) begin errors++; $display("FAIL reset_cnt_total got=%0d exp=0", cnt_total); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_stream();
      logic [3:0] vec [4];
      logic [2:0] cls [4];
      vec[0] = 4'b1000; cls[0] = 3'd1;
      vec[1] = 4'b1111; cls[1] = 3'd2;
      vec[2] = 4'b0110; cls[2] = 3'd3;
      vec[3] = 4'b0000; cls[3] = 3'd0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = vec[i]; in_valid = 1'b1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (out_data !== vec[i]) begin errors++; $display("FAIL stream_data[%0d] got=%b exp=%b", i, out_data, vec[i]); end
         checks++; if (out_class !== cls[i]) begin errors++; $display("FAIL stream_class[%0d] got=%0d exp=%0d", i, out_class, cls[i]); end
      end
      in_valid = 1'b0;
      checks++; if (cnt_onehot !== 8'd1) begin errors++; $display("FAIL stream_cnt_onehot got=%0d exp=1", cnt_onehot); end
      checks++; if (cnt_ones !== 8'd1) begin errors++; $display("FAIL stream_cnt_ones got=%0d exp=1", cnt_ones); end
      checks++; if (cnt_multi !== 8'd1) begin errors++; $display("FAIL stream_cnt_multi got=%0d exp=1", cnt_multi); end
      checks++; if (cnt_zero !== 8'd1) begin errors++; $display("FAIL stream_cnt_zero got=%0d exp=1", cnt_zero); end
      checks++; if (cnt_total !== 8'd4) begin errors++; $display("FAIL stream_cnt_total got=%0d exp=4", cnt_total); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (cnt_total !== 8'd0) begin errors++; $display("FAIL clr_cnt_total got=%0d exp=0", cnt_total); end
      checks++; if (cnt_zero !== 8'd0) begin errors++; $display("FAIL clr_cnt_zero got=%0d exp=0", cnt_zero); end
      checks++; if (cnt_onehot !== 8'd0) begin errors++; $display("FAIL clr_cnt_onehot got=%0d exp=0", cnt_onehot); end
   endtask

   task automatic test_unknown();
      logic [3:0] v;
      logic       unk;
      logic       exp_rdy;
      v = 4'b111x;
      unk = $isunknown(v);
`ifdef VEC_CLASS_STICKY_ERR_EN
      exp_rdy = !unk;
`else
      exp_rdy = 1'b1;
`endif
      out_ready = 1'b1; in_data = v; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_class !== (unk ? 3'd4 : 3'd3)) begin errors++; $display("FAIL unk_class got=%0d exp=%0d", out_class, unk ? 4 : 3); end
      checks++; if (out_data !== v) begin errors++; $display("FAIL unk_data got=%b exp=%b", out_data, v); end
      checks++; if (cnt_unknown !== (unk ? 8'd1 : 8'd0)) begin errors++; $display("FAIL unk_cnt got=%0d exp=%0d", cnt_unknown, unk); end
      checks++; if (cnt_total !== 8'd1) begin errors++; $display("FAIL unk_total got=%0d exp=1", cnt_total); end
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL unk_in_ready got=%b exp=%b", in_ready, exp_rdy); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unk_drain got=%b exp=0", out_valid); end
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL unk_in_ready_hold got=%b exp=%b", in_ready, exp_rdy); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL unk_clr_ready got=%b exp=1", in_ready); end
      checks++; if (cnt_unknown !== 8'd0) begin errors++; $display("FAIL unk_clr_cnt got=%0d exp=0", cnt_unknown); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0; in_data = 4'b0001; in_valid = 1'b1;
      tick();
      in_data = 4'b0011;
      for (int i = 0; i < 5; i++) begin
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
         tick();
         checks++; if (out_data !== 4'b0001 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%b exp=1/0001", i, out_valid, out_data); end
         checks++; if (cnt_total !== 8'd1) begin errors++; $display("FAIL bp_total[%0d] got=%0d exp=1", i, cnt_total); end
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_data !== 4'b0011 || out_class !== 3'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_next got=%b/%b/%0d exp=1/0011/3", out_valid, out_data, out_class); end
      checks++; if (cnt_total !== 8'd2) begin errors++; $display("FAIL bp_total_after got=%0d exp=2", cnt_total); end
      tick();
   endtask

   task automatic test_saturate();
      logic [1:0] exp;
      s_in_data = 4'b0100; s_in_valid = 1'b1; s_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp = (i >= 2) ? 2'd3 : 2'(i + 1);
         tick();
         checks++; if (s_cnt_onehot !== exp) begin errors++; $display("FAIL sat_onehot[%0d] got=%0d exp=%0d", i, s_cnt_onehot, exp); end
         checks++; if (s_cnt_total !== exp) begin errors++; $display("FAIL sat_total[%0d] got=%0d exp=%0d", i, s_cnt_total, exp); end
      end
      s_in_valid = 1'b0;
      tick();
   endtask

   task automatic test_clr_accept();
      in_data = 4'b0010; in_valid = 1'b1; out_ready = 1'b1; clr = 1'b1;
      tick();
      in_valid = 1'b0; clr = 1'b0;
      checks++; if (cnt_total !== 8'd0 || cnt_onehot !== 8'd0 || cnt_multi !== 8'd0) begin errors++; $display("FAIL clracc_cnt got=%0d/%0d/%0d exp=0/0/0", cnt_total, cnt_onehot, cnt_multi); end
      checks++; if (out_valid !== 1'b1 || out_class !== 3'd1 || out_data !== 4'b0010) begin errors++; $display("FAIL clracc_out got=%b/%0d/%b exp=1/1/0010", out_valid, out_class, out_data); end
      tick();
   endtask

   task automatic test_async_reset();
      in_data = 4'b1111; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || cnt_total !== 8'd1) begin errors++; $display("FAIL ar_pre got=%b/%0d exp=1/1", out_valid, cnt_total); end
      #2 rstn = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got=%b exp=0", out_valid); end
      checks++; if (cnt_total !== 8'd0 || cnt_ones !== 8'd0) begin errors++; $display("FAIL ar_cnt got=%0d/%0d exp=0/0", cnt_total, cnt_ones); end
      checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL ar_out_data got=%b exp=0000", out_data); end
      tick();
      rstn = 1'b1; out_ready = 1'b1; in_data = 4'b0110; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_class !== 3'd3 || out_data !== 4'b0110) begin errors++; $display("FAIL ar_resume got=%b/%0d/%b exp=1/3/0110", out_valid, out_class, out_data); end
      checks++; if (cnt_multi !== 8'd1 || cnt_total !== 8'd1) begin errors++; $display("FAIL ar_resume_cnt got=%0d/%0d exp=1/1", cnt_multi, cnt_total); end
      tick();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_clr();
      test_unknown();
      test_back_to_back();
      test_saturate();
      test_clr_accept();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
